// File: rtl/bullet_plotter.sv
// bullet_plotter: scans every bullet slot once per frame and turns position changes into erase/draw pixel writes.
// Optional macro BULLET_PLOTTER_STATS_EN adds a drawn_count output (active slots seen in the last scan).
module bullet_plotter #(
  parameter int         NUM_SLOTS     = 160,
  parameter logic [2:0] BULLET_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120,
  localparam int        IDX_W         = $clog2(NUM_SLOTS)
`ifdef BULLET_PLOTTER_STATS_EN
  , localparam int      CNT_W         = $clog2(NUM_SLOTS + 1)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  output logic [IDX_W-1:0] slot_sel,
  input  logic [7:0]       slot_x,
  input  logic [6:0]       slot_y,
  input  logic             slot_plot,
  output logic [7:0]       x,
  output logic [6:0]       y,
  output logic [2:0]       colour,
  output logic             writeEn,
  output logic             busy,
  output logic             done,
  output logic             overrun
`ifdef BULLET_PLOTTER_STATS_EN
  , output logic [CNT_W-1:0] drawn_count
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    ERASE = 3'd3,
    DRAW  = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t state;

  logic [7:0]           prev_x [NUM_SLOTS];
  logic [6:0]           prev_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] prev_v;

  logic [7:0] lat_x;
  logic [6:0] lat_y;
  logic       lat_v;
  logic       lat_draw;

  logic [7:0] sh_x;
  logic [6:0] sh_y;
  logic       sh_v;
  logic       cur_v;
  logic       moved;
  logic       need_erase;
  logic       need_draw;

  // Compare the pool data for the selected slot with its shadow entry.
  always_comb begin
    sh_x       = prev_x[slot_sel];
    sh_y       = prev_y[slot_sel];
    sh_v       = prev_v[slot_sel];
    cur_v      = slot_plot && (slot_x < 8'(SCREEN_W)) && (slot_y < 7'(SCREEN_H));
    moved      = (slot_x != sh_x) || (slot_y != sh_y);
    need_erase = sh_v && (!cur_v || moved);
    need_draw  = cur_v && (!sh_v || moved);
  end

  // Shadow positions carry no reset; prev_v alone says whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (state == NEXT) begin
      prev_x[slot_sel] <= lat_x;
      prev_y[slot_sel] <= lat_y;
    end
  end

  // Scan FSM with registered pixel-port and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      slot_sel <= '0;
      x        <= 8'd0;
      y        <= 7'd0;
      colour   <= 3'd0;
      writeEn  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      prev_v   <= '0;
      lat_x    <= 8'd0;
      lat_y    <= 7'd0;
      lat_v    <= 1'b0;
      lat_draw <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      done    <= 1'b0;
      overrun <= frame_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state    <= FETCH;
            slot_sel <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          lat_x    <= slot_x;
          lat_y    <= slot_y;
          lat_v    <= cur_v;
          lat_draw <= need_draw;
          if (need_erase) begin
            state   <= ERASE;
            writeEn <= 1'b1;
            x       <= sh_x;
            y       <= sh_y;
            colour  <= BG_COLOUR;
          end else if (need_draw) begin
            state   <= DRAW;
            writeEn <= 1'b1;
            x       <= slot_x;
            y       <= slot_y;
            colour  <= BULLET_COLOUR;
          end else begin
            state <= NEXT;
          end
        end
        ERASE: begin
          if (lat_draw) begin
            state   <= DRAW;
            writeEn <= 1'b1;
            x       <= lat_x;
            y       <= lat_y;
            colour  <= BULLET_COLOUR;
          end else begin
            state <= NEXT;
          end
        end
        DRAW: state <= NEXT;
        NEXT: begin
          prev_v[slot_sel] <= lat_v;
          if (slot_sel == IDX_W'(NUM_SLOTS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            slot_sel <= slot_sel + IDX_W'(1);
            state    <= FETCH;
          end
        end
        DONE: begin
          slot_sel <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BULLET_PLOTTER_STATS_EN
  logic [CNT_W-1:0] scan_cnt;

  // Count slots holding a visible bullet; publish the total when the scan finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt    <= '0;
      drawn_count <= '0;
    end else begin
      if (state == IDLE && frame_tick) begin
        scan_cnt <= '0;
      end else if (state == NEXT && lat_v) begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
      if (state == DONE) begin
        drawn_count <= scan_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bullet_plotter.sv
// Self-checking bench for bullet_plotter: directed plan steps plus random pools against a per-frame behavioural model.
module tb_bullet_plotter;
  localparam int N = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [7:0] slot_sel;
  logic [7:0] slot_x;
  logic [6:0] slot_y;
  logic       slot_plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, busy, done, overrun;
`ifdef BULLET_PLOTTER_STATS_EN
  logic [7:0] drawn_count;
`endif

  bullet_plotter dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .slot_sel(slot_sel),
    .slot_x(slot_x), .slot_y(slot_y), .slot_plot(slot_plot),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(busy), .done(done), .overrun(overrun)
`ifdef BULLET_PLOTTER_STATS_EN
    , .drawn_count(drawn_count)
`endif
  );

  always #5 clk = ~clk;

  // Bullet pool: registered read, data valid the cycle after slot_sel changes.
  logic [7:0] px [N];
  logic [6:0] py [N];
  logic       pp [N];
  always @(posedge clk) begin
    slot_x    <= px[slot_sel];
    slot_y    <= py[slot_sel];
    slot_plot <= pp[slot_sel];
  end

  typedef struct { int x; int y; int c; int cyc; } wr_t;
  wr_t exp_q[$];
  wr_t got_q[$];
  int  mx [N];
  int  my [N];
  bit  mv [N];
  int  exp_cnt;
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Screen-level model: which pixels must change this frame and when; returns the done cycle.
  function automatic int model_scan();
    int len = 1;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      bit cur;
      bit chg;
      int wcyc;
      cur  = pp[i] && (px[i] < 160) && (py[i] < 120);
      chg  = (int'(px[i]) != mx[i]) || (int'(py[i]) != my[i]);
      wcyc = len + 2;
      if (mv[i] && (!cur || chg)) begin
        exp_q.push_back('{mx[i], my[i], 0, wcyc});
        wcyc++;
      end
      if (cur && (!mv[i] || chg)) begin
        exp_q.push_back('{int'(px[i]), int'(py[i]), 7, wcyc});
        wcyc++;
      end
      len   = wcyc + 1;
      mx[i] = int'(px[i]);
      my[i] = int'(py[i]);
      mv[i] = cur;
      if (cur) exp_cnt++;
    end
    return len;
  endfunction

  function automatic void clear_pool();
    for (int i = 0; i < N; i++) begin
      px[i] = 8'd0;
      py[i] = 7'd0;
      pp[i] = 1'b0;
    end
  endfunction

  function automatic void rand_pool();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        px[i] = 8'($urandom_range(0, 175));
        py[i] = 7'($urandom_range(0, 127));
        pp[i] = ($urandom_range(0, 3) == 0);
      end
    end
  endfunction

  task automatic run_scan(input string name, input int extra_tick);
    int exp_len, done_cyc, n_done, n_ovr, busy_bad;
    exp_len  = model_scan();
    got_q.delete();
    done_cyc = -1;
    n_done   = 0;
    n_ovr    = 0;
    busy_bad = 0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int cyc = 1; cyc <= exp_len + 3; cyc++) begin
      if (writeEn === 1'b1) got_q.push_back('{int'(x), int'(y), int'(colour), cyc});
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (overrun === 1'b1) n_ovr++;
      if (cyc < exp_len && busy !== 1'b1) busy_bad++;
      if (cyc >= exp_len && busy !== 1'b0) busy_bad++;
      frame_tick = (cyc == extra_tick);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    check({name, ".done_cyc"}, done_cyc, exp_len);
    check({name, ".n_done"}, n_done, 1);
    check({name, ".overrun"}, n_ovr, (extra_tick > 0) ? 1 : 0);
    check({name, ".busy"}, busy_bad, 0);
    check({name, ".n_writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s.wr%0d.x", name, i), got_q[i].x, exp_q[i].x);
      check($sformatf("%s.wr%0d.y", name, i), got_q[i].y, exp_q[i].y);
      check($sformatf("%s.wr%0d.colour", name, i), got_q[i].c, exp_q[i].c);
      check($sformatf("%s.wr%0d.cycle", name, i), got_q[i].cyc, exp_q[i].cyc);
    end
`ifdef BULLET_PLOTTER_STATS_EN
    check({name, ".drawn_count"}, drawn_count, exp_cnt);
`endif
  endtask

  initial begin
    bit found;
    reset      = 1'b1;
    frame_tick = 1'b0;
    clear_pool();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      my[i] = 0;
      mv[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst.slot_sel", slot_sel, 0);
    check("rst.x", x, 0);
    check("rst.y", y, 0);
    check("rst.colour", colour, 0);
    check("rst.writeEn", writeEn, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.overrun", overrun, 0);
`ifdef BULLET_PLOTTER_STATS_EN
    check("rst.drawn_count", drawn_count, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    run_scan("empty", 0);

    px[5] = 8'd40; py[5] = 7'd30; pp[5] = 1'b1;
    run_scan("first_draw", 0);
    run_scan("unchanged", 0);

    px[5] = 8'd41;
    run_scan("move", 0);

    px[5] = 8'd160;
    run_scan("offscreen", 0);
    px[5] = 8'd41;
    run_scan("back", 0);
    pp[5] = 1'b0;
    run_scan("plot_drop", 0);
    run_scan("idle_slot", 0);

    px[7] = 8'd3; py[7] = 7'd119; pp[7] = 1'b1;
    run_scan("overrun_mid", 20);
    run_scan("overrun_done", model_scan_len_peek());

    for (int r = 0; r < 4; r++) begin
      rand_pool();
      run_scan($sformatf("rand%0d", r), 0);
    end

    // Abort a scan while slot 0 is being drawn.
    px[0] = 8'd100; py[0] = 7'd100; pp[0] = 1'b1;
    if (mv[0] && mx[0] == 100 && my[0] == 100) px[0] = 8'd101;
    found = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (writeEn === 1'b1 && colour === 3'b111) found = 1'b1;
      else @(negedge clk);
    end
    check("abort.found_draw", found, 1);
    reset = 1'b1;
    #1;
    check("abort.writeEn", writeEn, 0);
    check("abort.busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    @(negedge clk);
    run_scan("redraw", 0);

    clear_pool();
    run_scan("wipe", 0);
    px[2]   = 8'd10; py[2]   = 7'd10;  pp[2]   = 1'b1;
    px[50]  = 8'd20; py[50]  = 7'd119; pp[50]  = 1'b1;
    px[100] = 8'd30; py[100] = 7'd120; pp[100] = 1'b1;
    run_scan("three_active", 0);
`ifdef BULLET_PLOTTER_STATS_EN
    check("stats.three_active", drawn_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Done-cycle index of the next scan without disturbing the model shadow.
  function automatic int model_scan_len_peek();
    int len = 1;
    for (int i = 0; i < N; i++) begin
      bit cur;
      bit chg;
      cur = pp[i] && (px[i] < 160) && (py[i] < 120);
      chg = (int'(px[i]) != mx[i]) || (int'(py[i]) != my[i]);
      len += 3;
      if (mv[i] && (!cur || chg)) len++;
      if (cur && (!mv[i] || chg)) len++;
    end
    return len;
  endfunction

endmodule

// File: doc/bullet_plotter.md
Name: bullet_plotter

Overview:
- Reader side of the bullet pool interface: once per frame, scans every bullet slot (x, y, plot flag) and converts position changes into single-pixel writes for the VGA adapter.
- Erases each bullet's previously drawn pixel and draws its new one.
- Holds a shadow copy of the last drawn position per slot.
- Sits between the bullet pool and the VGA adapter write port.

Parameters:
- NUM_SLOTS, 160, number of bullet slots scanned per frame (index width = clog2(NUM_SLOTS)).
- BULLET_COLOUR, 3'b111, colour written when drawing.
- BG_COLOUR, 3'b000, colour written when erasing.
- SCREEN_W, 160, x values >= SCREEN_W are off-screen.
- SCREEN_H, 120, y values >= SCREEN_H are off-screen.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse that starts a scan.
- slot_sel  out  clog2(NUM_SLOTS)  slot index presented to the bullet pool.
- slot_x  in  8  x of the selected slot, valid the cycle after slot_sel changes.
- slot_y  in  7  y of the selected slot, same timing as slot_x.
- slot_plot  in  1  plot_bullet flag of the selected slot, same timing as slot_x.
- x  out  8  VGA pixel x.
- y  out  7  VGA pixel y.
- colour  out  3  VGA pixel colour.
- writeEn  out  1  VGA write strobe, one cycle per pixel.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan completes.
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Behaviour:
- Reset (async, immediate):
  - FSM to IDLE.
  - slot_sel=0, x=0, y=0, colour=0, writeEn=0, busy=0, done=0, overrun=0.
  - All shadow valid bits cleared. Pixels already on screen are not erased; screen clear is handled elsewhere.
- Shadow storage per slot: prev_x[7:0], prev_y[6:0], prev_v.
- FSM states: IDLE, FETCH, LATCH, ERASE, DRAW, NEXT, DONE.
- IDLE:
  - frame_tick=1 -> FETCH; slot_sel=0, busy=1.
- FETCH:
  - slot_sel is stable. Wait one cycle for pool data -> LATCH.
- LATCH:
  - Register slot_x, slot_y, slot_plot.
  - cur_v = slot_plot AND slot_x<SCREEN_W AND slot_y<SCREEN_H.
  - need_erase = prev_v AND (NOT cur_v OR slot_x!=prev_x OR slot_y!=prev_y).
  - need_draw = cur_v AND (NOT prev_v OR position changed).
  - Next state:
    - need_erase -> ERASE.
    - else if need_draw -> DRAW.
    - else -> NEXT.
- ERASE:
  - writeEn=1, x=prev_x, y=prev_y, colour=BG_COLOUR for exactly one cycle.
  - Next: need_draw -> DRAW, else -> NEXT.
- DRAW:
  - writeEn=1, x=latched x, y=latched y, colour=BULLET_COLOUR for one cycle -> NEXT.
- NEXT:
  - Shadow[slot] <= {latched x, latched y, cur_v}. This happens every slot, including unchanged ones.
  - If slot_sel==NUM_SLOTS-1 -> DONE.
  - Else slot_sel+1 -> FETCH.
- DONE:
  - done=1 one cycle, busy=0, slot_sel=0 -> IDLE.
- writeEn is 0 in every state except ERASE and DRAW. x/y/colour hold their last values when writeEn=0.
- Per-slot cost: 3 cycles (no write), 4 (one write), or 5 (erase+draw).
- Scan length: min 3*NUM_SLOTS+1, max 5*NUM_SLOTS+1 cycles from the frame_tick cycle to done.
- frame_tick while busy: ignored, scan continues unaffected, overrun pulses one cycle.
- frame_tick in the same cycle done pulses: the FSM is in DONE, so the tick counts as busy -> overrun.
- Active bullet at an unchanged position: no pixel writes; the pixel stays on screen.
- Bullet going off-screen (e.g. x=160): erase old pixel only; shadow prev_v=0.
- Reset mid-scan: aborts immediately with no further writes; the next scan redraws all active bullets because prev_v=0.

Optional Feature:
- Macro: BULLET_PLOTTER_STATS_EN.
- When defined:
  - Adds output port drawn_count [clog2(NUM_SLOTS+1)-1:0].
  - Internal counter clears at scan start and increments once per slot with cur_v=1, whether or not a draw occurred.
  - drawn_count is updated in DONE and held until the next DONE; reset value 0.
- When undefined: no port and no counter; all other behaviour is identical.

Test Plan:
- Reset, all slots slot_plot=0, frame_tick -> zero writeEn pulses; done exactly 3*NUM_SLOTS+1 cycles after the tick; busy high throughout.
- Slot 5 = (40,30) plot=1, one scan -> one write (40,30,3'b111); second scan unchanged -> zero writes.
- Slot 5 moves to (41,30) -> erase (40,30,3'b000), then next cycle draw (41,30,3'b111); no other writes.
- Slot 5 plot drops to 0, or x=160 -> single erase (41,30,3'b000); next scan with plot=0 -> no writes.
- frame_tick reasserted 20 cycles into a scan -> overrun one-cycle pulse, scan completes normally, exactly one done pulse.
- Assert reset mid-DRAW -> writeEn=0 immediately; next scan redraws all active slots. With BULLET_PLOTTER_STATS_EN, 3 active slots (one at y=120) -> drawn_count=2.
